// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared camera types, readout state encoding and default timing
//
// Contents:
//   readout_state_t  row-readout sequencer states (3-bit encoding)
//   NRE_INACTIVE     all-ones row-enable pattern, sliced to the array width by users
//   DEF_*            default readout timing, also used by the camera control FSM
//   cnt_max          larger of two cycle counts, used to size phase counters
package camera_pkg;

    typedef enum logic [2:0] {
        RD_IDLE      = 3'd0,
        RD_WAIT_SINK = 3'd1,
        RD_SELECT    = 3'd2,
        RD_CONVERT   = 3'd3,
        RD_RELEASE   = 3'd4,
        RD_DONE      = 3'd5
    } readout_state_t;

    localparam int MAX_ROWS = 64;
    localparam logic [MAX_ROWS-1:0] NRE_INACTIVE = '1;

    localparam int DEF_NUM_ROWS      = 2;
    localparam int DEF_SETTLE_CYCLES = 1;
    localparam int DEF_ADC_CYCLES    = 1;

    function automatic int cnt_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - clearable up-counter with terminal-count compare
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        synchronous clear (takes priority over enable)
//   enable       count up by one
//   limit        terminal value; terminal is high while count == limit
//   count        current count
//   terminal     count has reached limit
module phase_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == limit);

endmodule

// File: rtl/readout_sequencer.sv
// rtl/readout_sequencer.sv - row-by-row pixel readout sequencer (NRE select, ADC strobe)
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        one-cycle request from the camera FSM to begin readout
//   abort        cancel an in-progress readout, back to IDLE without pulses
//   sink_ready   downstream can accept one row; sampled only while waiting
//   nre          active-low row enables, bit i selects row i
//   adc_enable   ADC convert strobe
//   row_done     one-cycle pulse after each row conversion
//   row_idx      row currently / last addressed
//   busy         high in every state except IDLE
//   done         one-cycle pulse when all rows are read
module readout_sequencer
    import camera_pkg::*;
#(
    parameter int NUM_ROWS      = DEF_NUM_ROWS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ADC_CYCLES    = DEF_ADC_CYCLES,
    parameter int CNT_W         = $clog2(cnt_max(SETTLE_CYCLES, ADC_CYCLES) + 1),
    parameter int ROW_W         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                sink_ready,
    output logic [NUM_ROWS-1:0] nre,
    output logic                adc_enable,
    output logic                row_done,
    output logic [ROW_W-1:0]    row_idx,
    output logic                busy,
    output logic                done
);

    if (NUM_ROWS < 1 || NUM_ROWS > MAX_ROWS) begin : g_bad_rows
        $error("readout_sequencer: NUM_ROWS must be in 1..%0d", MAX_ROWS);
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("readout_sequencer: SETTLE_CYCLES must be >= 1");
    end
    if (ADC_CYCLES < 1) begin : g_bad_adc
        $error("readout_sequencer: ADC_CYCLES must be >= 1");
    end

    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ADC_LIM    = CNT_W'(ADC_CYCLES - 1);

    readout_state_t   state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_limit;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_tc;
    logic             row_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RD_IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_limit = '0;
        case (state_q)
            RD_IDLE: begin
                if (start && !abort) begin
                    state_d = RD_WAIT_SINK;
                    row_d   = '0;
                end
            end
            RD_WAIT_SINK: begin
                if (sink_ready) begin
                    state_d = RD_SELECT;
                end
            end
            RD_SELECT: begin
                cnt_limit = SETTLE_LIM;
                if (cnt_tc) begin
                    state_d = RD_CONVERT;
                end
            end
            RD_CONVERT: begin
                cnt_limit = ADC_LIM;
                if (cnt_tc) begin
                    state_d = RD_RELEASE;
                end
            end
            RD_RELEASE: begin
                if (row_q == LAST_ROW) begin
                    state_d = RD_DONE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = RD_WAIT_SINK;
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
        // Abort overrides every transition out of a running state.
        if (abort && state_q != RD_IDLE) begin
            state_d = RD_IDLE;
        end
    end

    // The counter restarts on every state change so each phase counts from zero.
    assign cnt_clear  = (state_d != state_q);
    assign cnt_enable = (state_q == RD_SELECT) || (state_q == RD_CONVERT);

    phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .limit    (cnt_limit),
        .count    (cnt_value),
        .terminal (cnt_tc)
    );

    assign row_active = (state_q == RD_SELECT) || (state_q == RD_CONVERT);

    always_comb begin
        nre = NRE_INACTIVE[NUM_ROWS-1:0];
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (row_active && row_q == ROW_W'(i)) begin
                nre[i] = 1'b0;
            end
        end
    end

    assign adc_enable = (state_q == RD_CONVERT);
    assign row_done   = (state_q == RD_RELEASE);
    assign done       = (state_q == RD_DONE);
    assign busy       = (state_q != RD_IDLE);
    assign row_idx    = row_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// tb/tb_readout_sequencer.sv - directed self-checking bench for readout_sequencer
module tb_readout_sequencer;

    logic       clk;
    logic       reset_a, start_a, abort_a, sink_a;
    logic [1:0] nre_a;
    logic       adc_a, rd_a, busy_a, done_a;
    logic [0:0] ridx_a;

    logic       reset_b, start_b, abort_b, sink_b;
    logic [3:0] nre_b;
    logic       adc_b, rd_b, busy_b, done_b;
    logic [1:0] ridx_b;

    int errors = 0;
    int checks = 0;
    int q_a[$];
    int q_b[$];
    int done_pend_a = 0;
    int done_pend_b = 0;
    bit mon_en = 0;

    readout_sequencer dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .start      (start_a),
        .abort      (abort_a),
        .sink_ready (sink_a),
        .nre        (nre_a),
        .adc_enable (adc_a),
        .row_done   (rd_a),
        .row_idx    (ridx_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    readout_sequencer #(
        .NUM_ROWS      (4),
        .SETTLE_CYCLES (3),
        .ADC_CYCLES    (2)
    ) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .start      (start_b),
        .abort      (abort_b),
        .sink_ready (sink_b),
        .nre        (nre_b),
        .adc_enable (adc_b),
        .row_done   (rd_b),
        .row_idx    (ridx_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference timeline: cycle 0 is the cycle in which start is sampled.
    // Each row spans WAIT, s SELECT cycles, a CONVERT cycles, RELEASE.
    task automatic chk_model(input string tag, input int c, input int n, input int s, input int a,
                             input logic [31:0] nre, input logic [31:0] adc, input logic [31:0] busy,
                             input logic [31:0] done, input logic [31:0] rd, input logic [31:0] ridx);
        int p, ph, st, row;
        logic [31:0] exp_nre;
        p = 2 + s + a;
        if (c >= 1 && c <= n * p) begin
            row = (c - 1) / p;
            ph  = (c - 1) % p;
            st  = (ph == 0) ? 1 : (ph <= s) ? 2 : (ph <= s + a) ? 3 : 4;
        end else if (c == n * p + 1) begin
            st  = 5;
            row = n - 1;
        end else begin
            st  = 0;
            row = n - 1;
        end
        exp_nre = (32'd1 << n) - 32'd1;
        if (st == 2 || st == 3) exp_nre = exp_nre & ~(32'd1 << row);
        chk($sformatf("%s/c%0d nre", tag, c), nre, exp_nre);
        chk($sformatf("%s/c%0d adc_enable", tag, c), adc, 32'(st == 3));
        chk($sformatf("%s/c%0d busy", tag, c), busy, 32'(st != 0));
        chk($sformatf("%s/c%0d done", tag, c), done, 32'(st == 5));
        chk($sformatf("%s/c%0d row_done", tag, c), rd, 32'(st == 4));
        if (st != 0) chk($sformatf("%s/c%0d row_idx", tag, c), ridx, 32'(row));
    endtask

    task automatic run_a(input string tag, input int restart_c);
        start_a = 1'b1;
        q_a.push_back(0);
        q_a.push_back(1);
        done_pend_a++;
        tick();
        for (int c = 1; c <= 11; c++) begin
            chk_model(tag, c, 2, 1, 1, nre_a, adc_a, busy_a, done_a, rd_a, ridx_a);
            start_a = (c == restart_c);
            tick();
        end
        start_a = 1'b0;
    endtask

    // Scoreboard and structural invariants, sampled at the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("a.nre_onehot0", 32'($countones(~nre_a) <= 1), 32'd1);
            chk("a.adc_needs_row", 32'(!adc_a || (~nre_a != 2'b00)), 32'd1);
            chk("b.nre_onehot0", 32'($countones(~nre_b) <= 1), 32'd1);
            chk("b.adc_needs_row", 32'(!adc_b || (~nre_b != 4'b0000)), 32'd1);
            if (rd_a === 1'b1) begin
                chk("a.row_done_expected", 32'(q_a.size() > 0), 32'd1);
                if (q_a.size() > 0) chk("a.row_idx_sb", 32'(ridx_a), 32'(q_a.pop_front()));
            end
            if (rd_b === 1'b1) begin
                chk("b.row_done_expected", 32'(q_b.size() > 0), 32'd1);
                if (q_b.size() > 0) chk("b.row_idx_sb", 32'(ridx_b), 32'(q_b.pop_front()));
            end
            if (done_a === 1'b1) begin
                chk("a.done_expected", 32'(done_pend_a > 0), 32'd1);
                if (done_pend_a > 0) done_pend_a--;
            end
            if (done_b === 1'b1) begin
                chk("b.done_expected", 32'(done_pend_b > 0), 32'd1);
                if (done_pend_b > 0) done_pend_b--;
            end
        end
    end

    initial begin
        reset_a = 1'b1; start_a = 1'b0; abort_a = 1'b0; sink_a = 1'b1;
        reset_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; sink_b = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;

        // Reset state of both instances
        chk("rst.a.nre", nre_a, 32'h3);
        chk("rst.a.adc", adc_a, 0);
        chk("rst.a.row_done", rd_a, 0);
        chk("rst.a.busy", busy_a, 0);
        chk("rst.a.done", done_a, 0);
        chk("rst.a.row_idx", ridx_a, 0);
        chk("rst.b.nre", nre_b, 32'hf);
        chk("rst.b.busy", busy_b, 0);
        chk("rst.b.row_idx", ridx_b, 0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        tick();

        // 1: default timing, sink always ready
        run_a("t1", -1);

        // 2: sink held off for 5 cycles after start
        sink_a  = 1'b0;
        start_a = 1'b1;
        q_a.push_back(0);
        q_a.push_back(1);
        done_pend_a++;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk_model($sformatf("t2w%0d", c), 1, 2, 1, 1, nre_a, adc_a, busy_a, done_a, rd_a, ridx_a);
            if (c < 6) tick();
        end
        sink_a = 1'b1;
        tick();
        for (int c = 7; c <= 16; c++) begin
            chk_model("t2", c - 5, 2, 1, 1, nre_a, adc_a, busy_a, done_a, rd_a, ridx_a);
            tick();
        end

        // 3: abort during row 0 conversion, then a clean restart
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        chk("t3.adc_before_abort", adc_a, 1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("t3.nre_after_abort", nre_a, 32'h3);
        chk("t3.adc_after_abort", adc_a, 0);
        chk("t3.busy_after_abort", busy_a, 0);
        chk("t3.row_done_after_abort", rd_a, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3.idle_busy", busy_a, 0);
        end
        run_a("t3r", -1);

        // 4: wider instance, NUM_ROWS=4 SETTLE=3 ADC=2
        start_b = 1'b1;
        for (int r = 0; r < 4; r++) q_b.push_back(r);
        done_pend_b++;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            chk_model("t4", c, 4, 3, 2, nre_b, adc_b, busy_b, done_b, rd_b, ridx_b);
            tick();
        end

        // 5: start re-pulsed in CONVERT is ignored; start+abort in IDLE stays idle
        run_a("t5", 3);
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("t5.start_abort_busy", busy_a, 0);
        chk("t5.start_abort_nre", nre_a, 32'h3);
        tick();
        chk("t5.start_abort_busy2", busy_a, 0);

        // 6: reset during SELECT of row 1
        start_a = 1'b1;
        q_a.push_back(0);
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6.nre_select_row1", nre_a, 32'h1);
        reset_a = 1'b1;
        tick();
        chk("t6.nre", nre_a, 32'h3);
        chk("t6.adc", adc_a, 0);
        chk("t6.row_done", rd_a, 0);
        chk("t6.busy", busy_a, 0);
        chk("t6.done", done_a, 0);
        chk("t6.row_idx", ridx_a, 0);
        reset_a = 1'b0;
        tick();
        chk("t6.busy_after", busy_a, 0);
        tick();

        chk("end.a.rows_outstanding", 32'(q_a.size()), 0);
        chk("end.b.rows_outstanding", 32'(q_b.size()), 0);
        chk("end.a.done_outstanding", 32'(done_pend_a), 0);
        chk("end.b.done_outstanding", 32'(done_pend_b), 0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
